// File: rtl/dm_cache_circuit.sv
// Direct-mapped read-only cache (256 lines x 4 words) with its backing 32K-word memory.
// A miss fills the whole line one word per cycle, then completes from FILL_DONE.
module dm_cache_circuit #(
    parameter int ADDR_W      = 15,
    parameter int WORD_W      = 32,
    parameter int LINES       = 256,
    parameter int BLOCK_WORDS = 4,
    parameter int MEM_WORDS   = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic              hit,
    output logic              finish
);

    localparam int OFF_W  = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int MEM_AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {COMPARE, FETCH, FILL_DONE} state_e;

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES][BLOCK_WORDS];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              hit_int;
    logic              fill_last;
    logic [MEM_AW-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] rd_word_unused;

    assign req_tag = address[ADDR_W-1 -: TAG_W];
    assign req_idx = address[OFF_W +: IDX_W];
    assign req_off = address[OFF_W-1:0];

    assign hit_int   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill_last = (state_q == FETCH) && (cnt_q == OFF_W'(BLOCK_WORDS - 1));

    // Main memory holds mem[i] = i and is never written, so its read port is the address itself.
    assign mem_addr  = MEM_AW'({req_tag, req_idx, cnt_q});
    assign mem_rdata = WORD_W'(mem_addr);

    // Requested word; kept for observation only, there is no data port.
    assign rd_word_unused = data_q[req_idx][req_off];

    assign hit    = (state_q == COMPARE) && hit_int;
    assign finish = hit || (state_q == FILL_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        case (state_q)
            COMPARE: begin
                if (!hit_int) begin
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cnt_d = cnt_q + 1'b1;
                if (fill_last) begin
                    valid_d[req_idx] = 1'b1;
                    state_d          = FILL_DONE;
                end
            end
            FILL_DONE: state_d = COMPARE;
            default:   state_d = COMPARE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COMPARE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Line storage is not reset; a line is only trusted once its valid bit is set at fill end.
    always_ff @(posedge clk) begin
        if (state_q == FETCH) begin
            data_q[req_idx][cnt_q] <= mem_rdata;
            if (fill_last) begin
                tag_q[req_idx] <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_dm_cache_circuit.sv
// Scoreboard bench for dm_cache_circuit: a line-level cache model predicts hit, latency and word.
module tb_dm_cache_circuit;

    logic        clk;
    logic        rst;
    logic [14:0] address;
    logic        hit;
    logic        finish;

    dm_cache_circuit dut (
        .clk    (clk),
        .rst    (rst),
        .address(address),
        .hit    (hit),
        .finish (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          hit;
        int          lat;
        logic [31:0] word;
        int          addr;
    } exp_t;

    exp_t q[$];
    bit       m_valid [256];
    bit [4:0] m_tag   [256];

    int checks    = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int hits_seen = 0;
    int ncyc      = 0;
    int cyc       = 0;

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Reset clears every line in the model; an abandoned request yields no completion.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        q.delete();
    endtask

    task automatic wait_finish();
        int d0 = done_cnt;
        int i  = 0;
        while (done_cnt == d0 && i < 20) begin
            @(posedge clk);
            i++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%0d: no finish within 20 cycles", address);
            finish_sim();
        end
        #1;
    endtask

    task automatic issue(input int a, input bit wait_done);
        exp_t e;
        int   idx;
        int   t;
        idx    = (a / 4) % 256;
        t      = a / 1024;
        e.hit  = m_valid[idx] && (m_tag[idx] == 5'(t));
        if (!e.hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = 5'(t);
        end
        e.lat  = e.hit ? 1 : 6;
        e.word = 32'(a);
        e.addr = a;
        q.push_back(e);
        address = 15'(a);
        if (wait_done) wait_finish();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: every falling edge, compare completions against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (hit || finish) begin
                errors++;
                $display("FAIL reset_outputs: hit=%0b finish=%0b, required 0/0", hit, finish);
            end
            cyc = 0;
        end else begin
            cyc++;
            ncyc++;
            if (hit) begin
                checks++;
                if (!finish) begin
                    errors++;
                    $display("FAIL hit_without_finish: hit=1 finish=0");
                end
            end
            if (finish) begin
                exp_t e;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_finish: addr=%0d with empty scoreboard", address);
                end else begin
                    e = q.pop_front();
                    if (hit !== e.hit) begin
                        errors++;
                        $display("FAIL hit addr=%0d: got %0b, required %0b", e.addr, hit, e.hit);
                    end
                    checks++;
                    if (cyc != e.lat) begin
                        errors++;
                        $display("FAIL latency addr=%0d: got %0d, required %0d", e.addr, cyc, e.lat);
                    end
                    checks++;
                    if (dut.rd_word_unused !== e.word) begin
                        errors++;
                        $display("FAIL word addr=%0d: got %h, required %h", e.addr, dut.rd_word_unused, e.word);
                    end
                end
                if (hit) hits_seen++;
                done_cnt++;
                cyc = 0;
            end
        end
    end

    initial begin
        int t0;
        int h0;
        rst     = 1'b0;
        address = 15'd1024;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset then idle, followed by block locality
        issue(1024, 1);
        for (int a = 1025; a <= 1027; a++) issue(a, 1);

        // Conflict on index 0
        issue(3072, 1);
        issue(1024, 1);
        issue(2048, 1);
        issue(1024, 1);

        // Full sweep from a clean cache
        do_reset(2);
        t0 = ncyc;
        h0 = hits_seen;
        for (int a = 1024; a <= 9215; a++) issue(a, 1);
        checks++;
        if (hits_seen - h0 != 6144) begin
            errors++;
            $display("FAIL sweep_hits: got %0d, required 6144", hits_seen - h0);
        end
        checks++;
        if (ncyc - t0 != 18432) begin
            errors++;
            $display("FAIL sweep_cycles: got %0d, required 18432", ncyc - t0);
        end

        // Reset during the third FETCH cycle of a miss
        issue(4096, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        issue(4096, 1);
        issue(4097, 1);

        // Top of memory
        for (int a = 32764; a <= 32767; a++) issue(a, 1);

        // Randomized traffic over a few tags and indices to mix hits and conflicts
        for (int n = 0; n < 400; n++) begin
            int t;
            int idx;
            int off;
            t   = int'($urandom_range(0, 3)) + ($urandom_range(0, 1) == 1 ? 28 : 0);
            idx = int'($urandom_range(0, 15)) + ($urandom_range(0, 1) == 1 ? 240 : 0);
            off = int'($urandom_range(0, 3));
            issue(t * 1024 + idx * 4 + off, 1);
        end

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", q.size());
        end
        finish_sim();
    end

endmodule

// File: doc/dm_cache_circuit.md
# dm_cache_circuit

Direct-mapped data cache with its backing main memory, packaged as a single self-contained block. A requester presents a 15-bit word address and holds it. The block reports completion with `finish` and, on that same cycle, whether the access hit the cache with `hit`. It serves as the top of the cache exercise: it contains the cache controller, the tag/valid/data arrays and a 32K-word memory model.

## Interface
Parameters:
- ADDR_W, 15, word-address width.
- WORD_W, 32, data word width.
- LINES, 256, number of cache lines.
- BLOCK_WORDS, 4, words per line.
- MEM_WORDS, 32768, main-memory depth.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- address  in  15  word address of the current request; held stable until `finish`.
- hit  out  1  high only together with `finish`, when the request was served from the cache.
- finish  out  1  one-cycle completion pulse for the current request.

## Operation
- Address split:
  - tag = address[14:10] (5 b)
  - index = address[9:2] (8 b)
  - offset = address[1:0] (2 b)
- Storage:
  - valid[256], tag[256]x5 and data[256][4]x32 arrays.
  - Main memory mem[32768]x32, initialised at time 0 with mem[i] = i (zero-extended).
  - Memory read is combinational.
- A request is always pending; there is no separate valid/request input. A new request starts on the cycle after `finish`.
- FSM states: COMPARE, FETCH, FILL_DONE.
  - COMPARE: hit_int = valid[index] & (tag[index] == tag field).
    - If hit_int: hit=1, finish=1, stay in COMPARE.
    - Otherwise: hit=0, finish=0, clear beat counter, go to FETCH.
  - FETCH: each cycle writes data[index][cnt] = mem[{tag, index, cnt}] and increments the 2-bit cnt. After cnt==3 is written, set valid[index]=1 and tag[index]=tag field, then go to FILL_DONE.
  - FILL_DONE: finish=1, hit=0, go to COMPARE.
- A miss replaces the indexed line unconditionally. There is no write path and no dirty state; the cache is read-only.
- The requested word is data[index][offset]. It is held internally and is not a port.

## Timing
- Reset (rst=0, async):
  - State goes to COMPARE, all valid bits clear, cnt=0.
  - hit and finish are forced to 0 for the whole time reset is held.
  - Memory contents are not altered by reset.
- `hit` and `finish` are Moore/Mealy outputs decoded from the current state and the array lookup. They are valid before the next rising edge.
- Hit latency: 1 cycle. The request is presented in COMPARE, and finish=hit=1 in that same cycle.
- Miss latency: 6 cycles, made of COMPARE (1), FETCH (4) and FILL_DONE (1). finish=1 and hit=0 in the 6th cycle.
- `hit` is never 1 when `finish` is 0.
- After `finish`, the requester may change `address` before the next rising edge. The following COMPARE cycle uses the new address.
- Address unchanged after `finish`: the next request re-accesses the same word. After a fill this is a 1-cycle hit.
- Reset asserted mid-FETCH:
  - The fill is abandoned and the line's valid bit remains 0.
  - After release, the same address misses again and takes the full 6 cycles.
- Boundaries:
  - Address 0x7FFF maps to index 255, offset 3, tag 31 (0x1F).
  - There is no wrap or overflow handling beyond the 15-bit address.

## Test plan
- Reset then idle: hold rst=0 for 2 cycles with address=1024 -> hit=0 and finish=0 throughout. After release, the first finish arrives 6 cycles later with hit=0.
- Block locality: sequential addresses 1024, 1025, 1026, 1027, each advanced on finish -> miss (6 cycles), then three 1-cycle hits. The internal word equals the address.
- Conflict: 1024, 2048, 1024 (same index 0, tags 1/2/1) -> three misses, 6 cycles each, hit=0 each time.
- Full sweep: addresses 1024..9215, advanced only on finish, hits counted on finish -> 6144 hits and 2048 misses. Total of 2048*6 + 6144 = 18432 cycles.
- Reset mid-fill: start a miss on 4096 and assert rst during the 3rd FETCH cycle. Re-access 4096 after release -> miss (hit=0, 6 cycles). Then 4097 -> hit in 1 cycle.
- Top of memory: 32764..32767 -> one miss then three hits. The internal word for 32767 is 0x00007FFF.
